// File: rtl/rt_timeout_scan_eng.sv
// Retransmit-timeout scan engine: round-robins active flows, compares the rx-state
// ack number against a per-flow timer record and asks the TX scheduler to retransmit on expiry.
module rt_timeout_scan_eng #(
    parameter int NUM_FLOWS         = 8,
    parameter int FLOWID_W          = $clog2(NUM_FLOWS),
    parameter int ACK_NUM_W         = 32,
    parameter int TIMESTAMP_W       = 32,
    parameter int RT_TIMEOUT_CYCLES = 1000,
    parameter int MAX_BACKOFF       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_flow_val,
    input  logic [FLOWID_W-1:0]  new_flow_flowid,
    input  logic [ACK_NUM_W-1:0] new_flow_our_ack_num,
    input  logic                 del_flow_val,
    input  logic [FLOWID_W-1:0]  del_flow_flowid,
    output logic                 rd_req_val,
    output logic [FLOWID_W-1:0]  rd_req_flowid,
    input  logic                 rd_req_rdy,
    input  logic                 rd_resp_val,
    input  logic [ACK_NUM_W-1:0] rd_resp_our_ack_num,
    output logic                 rd_resp_rdy,
    output logic                 sched_cmd_val,
    output logic [FLOWID_W-1:0]  sched_cmd_flowid,
    output logic                 sched_cmd_rt_set,
    input  logic                 sched_cmd_rdy,
    output logic [FLOWID_W:0]    active_cnt
);
    localparam int BO_W  = $clog2(MAX_BACKOFF + 1);
    localparam int REC_W = TIMESTAMP_W + ACK_NUM_W + BO_W;
    localparam logic [TIMESTAMP_W-1:0] RT_TS    = TIMESTAMP_W'(RT_TIMEOUT_CYCLES);
    localparam logic [FLOWID_W-1:0]    LAST_IDX = FLOWID_W'(NUM_FLOWS - 1);
    localparam logic [BO_W-1:0]        BO_MAX   = BO_W'(MAX_BACKOFF);

    typedef enum logic [2:0] {SCAN, REQ, RESP, RD_TMR, CALC, CMD, WR} state_t;

    state_t                 state_reg, state_next;
    logic [FLOWID_W-1:0]    idx_reg, idx_next, idx_inc;
    logic [TIMESTAMP_W-1:0] now_reg;
    logic [NUM_FLOWS-1:0]   active_reg, active_next, new_hit, del_hit;
    logic [FLOWID_W:0]      cnt_reg, cnt_next;
    logic                   abort_reg, abort_next, abort_eff, idx_hit;
    logic [ACK_NUM_W-1:0]   ack_reg, ack_next;
    logic [REC_W-1:0]       rec_reg, rec_next, new_rec;
    logic                   open_inc, close_dec;

    // Timer records: {deadline, last_ack, backoff}
    logic [REC_W-1:0]       tmr_mem [NUM_FLOWS];
    logic [REC_W-1:0]       tmr_rd_data;
    logic                   tmr_rd_en, tmr_wr_en;

    logic [TIMESTAMP_W-1:0] rd_deadline, time_left, rt_shift;
    logic [ACK_NUM_W-1:0]   rd_last_ack;
    logic [BO_W-1:0]        rd_backoff, bo_inc;
    logic                   expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow
            assign new_hit[gi]     = new_flow_val && (new_flow_flowid == FLOWID_W'(gi));
            assign del_hit[gi]     = del_flow_val && (del_flow_flowid == FLOWID_W'(gi));
            assign active_next[gi] = new_hit[gi] | (active_reg[gi] & ~del_hit[gi]);
        end
    endgenerate

    assign open_inc  = |(new_hit & ~active_reg);
    assign close_dec = |(del_hit & ~new_hit & active_reg);
    assign cnt_next  = cnt_reg + (FLOWID_W+1)'(open_inc) - (FLOWID_W+1)'(close_dec);

    assign idx_inc   = (idx_reg == LAST_IDX) ? '0 : idx_reg + FLOWID_W'(1);
    assign idx_hit   = (new_flow_val && (new_flow_flowid == idx_reg)) ||
                       (del_flow_val && (del_flow_flowid == idx_reg));
    assign abort_eff = abort_reg | idx_hit;
    assign new_rec   = {now_reg + RT_TS, new_flow_our_ack_num, {BO_W{1'b0}}};

    assign rd_deadline = tmr_rd_data[REC_W-1 -: TIMESTAMP_W];
    assign rd_last_ack = tmr_rd_data[BO_W +: ACK_NUM_W];
    assign rd_backoff  = tmr_rd_data[BO_W-1:0];
    // Modular difference keeps the compare correct when now wraps past the deadline.
    assign time_left   = rd_deadline - now_reg;
    assign expired     = (time_left == '0) || time_left[TIMESTAMP_W-1];
    assign bo_inc      = (rd_backoff >= BO_MAX) ? BO_MAX : rd_backoff + BO_W'(1);
    assign rt_shift    = RT_TS << bo_inc;

    assign rd_req_flowid    = idx_reg;
    assign sched_cmd_flowid = idx_reg;
    assign sched_cmd_rt_set = sched_cmd_val;
    assign active_cnt       = cnt_reg;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        abort_next    = abort_reg;
        ack_next      = ack_reg;
        rec_next      = rec_reg;
        tmr_rd_en     = 1'b0;
        tmr_wr_en     = 1'b0;
        rd_req_val    = 1'b0;
        rd_resp_rdy   = 1'b0;
        sched_cmd_val = 1'b0;
        if (state_reg != SCAN && idx_hit) abort_next = 1'b1;
        case (state_reg)
            SCAN: begin
                abort_next = 1'b0;
                if (active_next[idx_reg]) state_next = REQ;
                else                      idx_next   = idx_inc;
            end
            REQ: begin
                rd_req_val = 1'b1;
                if (rd_req_rdy) state_next = RESP;
            end
            RESP: begin
                rd_resp_rdy = 1'b1;
                if (rd_resp_val) begin
                    ack_next = rd_resp_our_ack_num;
                    if (abort_eff) begin
                        state_next = SCAN;
                        idx_next   = idx_inc;
                    end else begin
                        state_next = RD_TMR;
                    end
                end
            end
            RD_TMR: begin
                if (abort_eff) begin
                    state_next = SCAN;
                    idx_next   = idx_inc;
                end else if (!new_flow_val) begin
                    tmr_rd_en  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (abort_eff) begin
                    state_next = SCAN;
                    idx_next   = idx_inc;
                end else if (ack_reg != rd_last_ack) begin
                    rec_next   = {now_reg + RT_TS, ack_reg, {BO_W{1'b0}}};
                    state_next = WR;
                end else if (expired) begin
                    rec_next   = {now_reg + rt_shift, ack_reg, bo_inc};
                    state_next = CMD;
                end else begin
                    rec_next   = tmr_rd_data;
                    state_next = WR;
                end
            end
            CMD: begin
                sched_cmd_val = 1'b1;
                if (sched_cmd_rdy) begin
                    if (abort_eff) begin
                        state_next = SCAN;
                        idx_next   = idx_inc;
                    end else begin
                        state_next = WR;
                    end
                end
            end
            WR: begin
                if (abort_eff) begin
                    state_next = SCAN;
                    idx_next   = idx_inc;
                end else if (!new_flow_val) begin
                    tmr_wr_en  = 1'b1;
                    state_next = SCAN;
                    idx_next   = idx_inc;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= SCAN;
            idx_reg    <= '0;
            now_reg    <= '0;
            active_reg <= '0;
            cnt_reg    <= '0;
            abort_reg  <= 1'b0;
            ack_reg    <= '0;
            rec_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            now_reg    <= now_reg + TIMESTAMP_W'(1);
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
            abort_reg  <= abort_next;
            ack_reg    <= ack_next;
            rec_reg    <= rec_next;
        end
    end

    // Flow open owns both RAM ports in its cycle; engine accesses wait for it.
    always_ff @(posedge clk) begin
        if (new_flow_val)   tmr_mem[new_flow_flowid] <= new_rec;
        else if (tmr_wr_en) tmr_mem[idx_reg]         <= rec_reg;
        if (tmr_rd_en)      tmr_rd_data              <= tmr_mem[idx_reg];
    end
endmodule

// File: tb/tb_rt_timeout_scan_eng.sv
// Directed bench: instance A uses default sizing for timeout/backoff checks; instance B uses
// 5 flows and a 12-bit timestamp for scan order, wrap, stall and abort checks.
module tb_rt_timeout_scan_eng;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int tb_now = 0;

    // Instance A signals
    logic        a_new_val, a_del_val, a_req_val, a_resp_rdy, a_cmd_val, a_rt_set;
    logic [2:0]  a_new_id, a_del_id, a_req_id, a_cmd_id;
    logic [31:0] a_new_ack, a_resp_ack;
    logic        a_req_rdy, a_resp_val, a_cmd_rdy;
    logic [3:0]  a_cnt;
    logic [31:0] a_rx [8];
    assign a_resp_ack = a_rx[a_req_id];

    // Instance B signals
    logic        b_new_val, b_del_val, b_req_val, b_resp_rdy, b_cmd_val, b_rt_set;
    logic [2:0]  b_new_id, b_del_id, b_req_id, b_cmd_id;
    logic [31:0] b_new_ack, b_resp_ack;
    logic        b_req_rdy, b_resp_val, b_cmd_rdy, b_hold2;
    logic [3:0]  b_cnt;
    logic [31:0] b_rx [8];
    assign b_resp_ack = b_rx[b_req_id];
    assign b_resp_val = !(b_hold2 && (b_req_id == 3'd2));

    rt_timeout_scan_eng dut_a (
        .clk(clk), .rst(rst),
        .new_flow_val(a_new_val), .new_flow_flowid(a_new_id), .new_flow_our_ack_num(a_new_ack),
        .del_flow_val(a_del_val), .del_flow_flowid(a_del_id),
        .rd_req_val(a_req_val), .rd_req_flowid(a_req_id), .rd_req_rdy(a_req_rdy),
        .rd_resp_val(a_resp_val), .rd_resp_our_ack_num(a_resp_ack), .rd_resp_rdy(a_resp_rdy),
        .sched_cmd_val(a_cmd_val), .sched_cmd_flowid(a_cmd_id), .sched_cmd_rt_set(a_rt_set),
        .sched_cmd_rdy(a_cmd_rdy), .active_cnt(a_cnt)
    );

    rt_timeout_scan_eng #(.NUM_FLOWS(5), .TIMESTAMP_W(12), .RT_TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .rst(rst),
        .new_flow_val(b_new_val), .new_flow_flowid(b_new_id), .new_flow_our_ack_num(b_new_ack),
        .del_flow_val(b_del_val), .del_flow_flowid(b_del_id),
        .rd_req_val(b_req_val), .rd_req_flowid(b_req_id), .rd_req_rdy(b_req_rdy),
        .rd_resp_val(b_resp_val), .rd_resp_our_ack_num(b_resp_ack), .rd_resp_rdy(b_resp_rdy),
        .sched_cmd_val(b_cmd_val), .sched_cmd_flowid(b_cmd_id), .sched_cmd_rt_set(b_rt_set),
        .sched_cmd_rdy(b_cmd_rdy), .active_cnt(b_cnt)
    );

    always @(posedge clk) begin
        if (rst) tb_now <= 0;
        else     tb_now <= tb_now + 1;
    end

    int cmda_t[$], cmda_id[$], cmda_rt[$];
    int cmdb_t[$], cmdb_id[$];
    int rdb_t[$], rdb_id[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (a_cmd_val && a_cmd_rdy) begin
                cmda_t.push_back(tb_now);
                cmda_id.push_back(int'(a_cmd_id));
                cmda_rt.push_back(int'(a_rt_set));
                $display("[TB] A cmd flow %0d rt_set %0d at now %0d", a_cmd_id, a_rt_set, tb_now);
            end
            if (b_cmd_val && b_cmd_rdy) begin
                cmdb_t.push_back(tb_now);
                cmdb_id.push_back(int'(b_cmd_id));
                $display("[TB] B cmd flow %0d at now %0d", b_cmd_id, tb_now);
            end
            if (b_req_val && b_req_rdy) begin
                rdb_t.push_back(tb_now);
                rdb_id.push_back(int'(b_req_id));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before 3000000");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input longint obs, input longint lo, input longint hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_cmda(input int n, input int budget);
        int k = 0;
        while (cmda_t.size() < n && k < budget) begin tick(1); k++; end
        check("A_cmd_arrival", longint'(cmda_t.size() >= n), 1);
    endtask

    task automatic wait_cmdb(input int n, input int budget);
        int k = 0;
        while (cmdb_t.size() < n && k < budget) begin tick(1); k++; end
        check("B_cmd_arrival", longint'(cmdb_t.size() >= n), 1);
    endtask

    task automatic open_a(input int id, input int ack);
        a_new_val = 1'b1; a_new_id = 3'(id); a_new_ack = 32'(ack);
        tick(1);
        a_new_val = 1'b0;
    endtask

    task automatic open_b(input int id);
        b_new_val = 1'b1; b_new_id = 3'(id); b_new_ack = 32'd0;
        tick(1);
        b_new_val = 1'b0;
    endtask

    task automatic del_b(input int id);
        b_del_val = 1'b1; b_del_id = 3'(id);
        tick(1);
        b_del_val = 1'b0;
    endtask

    initial begin
        int tc, topen, held, n0, k, cnt2, cnt1;
        int gap [6];
        int nxt [5];
        gap = '{0, 1000, 2000, 4000, 8000, 16000};
        nxt = '{2, 0, 4, 0, 0};
        rst = 1'b1;
        a_new_val = 0; a_new_id = 0; a_new_ack = 0; a_del_val = 0; a_del_id = 0;
        a_req_rdy = 1; a_resp_val = 1; a_cmd_rdy = 1;
        b_new_val = 0; b_new_id = 0; b_new_ack = 0; b_del_val = 0; b_del_id = 0;
        b_req_rdy = 1; b_cmd_rdy = 1; b_hold2 = 0;
        for (int i = 0; i < 8; i++) begin a_rx[i] = 0; b_rx[i] = 0; end
        tick(4);

        check("rst_a_rd_req_val", a_req_val, 0);
        check("rst_a_rd_resp_rdy", a_resp_rdy, 0);
        check("rst_a_cmd_val", a_cmd_val, 0);
        check("rst_a_cmd_flowid", a_cmd_id, 0);
        check("rst_a_active_cnt", a_cnt, 0);
        check("rst_b_cmd_val", b_cmd_val, 0);
        check("rst_b_active_cnt", b_cnt, 0);
        rst = 1'b0;

        // First expiry and exponential backoff on flow 3
        while (tb_now != 10) tick(1);
        a_rx[3] = 100;
        open_a(3, 100);
        check("A_cnt_open", a_cnt, 1);
        wait_cmda(1, 1100);
        if (cmda_t.size() >= 1) begin
            check_rng("A_first_expiry_now", cmda_t[0], 1011, 1030);
            check("A_first_flowid", cmda_id[0], 3);
            check("A_first_rt_set", cmda_rt[0], 1);
        end
        for (int i = 2; i <= 6; i++) begin
            int g;
            g = (i == 6) ? 16000 : gap[i];
            wait_cmda(i, g + 100);
            if (cmda_t.size() >= i)
                check_rng($sformatf("A_backoff_gap_%0d", i), cmda_t[i-1] - cmda_t[i-2], g, g + 20);
        end
        foreach (cmda_id[i]) check($sformatf("A_cmd_flowid_%0d", i), cmda_id[i], 3);

        // Ack progress resets deadline and backoff
        a_rx[3] = 200;
        tc = tb_now;
        n0 = cmda_t.size();
        tick(950);
        check("A_no_cmd_after_ack_move", cmda_t.size(), n0);
        wait_cmda(n0 + 1, 200);
        if (cmda_t.size() > n0) check_rng("A_expiry_after_ack_move", cmda_t[n0] - tc, 1000, 1035);
        wait_cmda(n0 + 2, 2100);
        if (cmda_t.size() > n0 + 1) check_rng("A_backoff_reset_gap", cmda_t[n0+1] - cmda_t[n0], 2000, 2020);

        // Count boundaries: re-open active flow, delete inactive flow
        open_a(3, 200);
        check("A_cnt_reopen", a_cnt, 1);
        a_del_val = 1; a_del_id = 3'd5; tick(1); a_del_val = 0;
        check("A_cnt_del_inactive", a_cnt, 1);

        // Scan order 0,2,4,0 on 5 flows
        open_b(0); open_b(2); open_b(4);
        check("B_cnt_three", b_cnt, 3);
        tick(20);
        rdb_t.delete(); rdb_id.delete();
        tick(30);
        check("B_scan_reads", longint'(rdb_id.size() >= 4), 1);
        if (rdb_id.size() >= 4) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("B_scan_next_%0d", i), rdb_id[i+1], nxt[rdb_id[i]]);
                check($sformatf("B_scan_gap_%0d", i), rdb_t[i+1] - rdb_t[i], (rdb_id[i] == 4) ? 6 : 7);
            end
        end
        del_b(0); del_b(2); del_b(4);
        tick(2);
        check("B_cnt_cleared", b_cnt, 0);

        // Wrap-safe expiry: open 30 cycles before the 12-bit timestamp wraps
        while ((tb_now % 4096) != 4066) tick(1);
        cmdb_t.delete(); cmdb_id.delete();
        topen = tb_now;
        open_b(1);
        wait_cmdb(1, 200);
        if (cmdb_t.size() >= 1) begin
            check_rng("B_wrap_expiry", cmdb_t[0] - topen, 101, 112);
            check("B_wrap_flowid", cmdb_id[0], 1);
        end

        // Scheduler back-pressure: flow 3 expires first and its command must hold
        open_b(3);
        b_cmd_rdy = 1'b0;
        k = 0;
        while (!b_cmd_val && k < 300) begin tick(1); k++; end
        check("B_stall_cmd_seen", b_cmd_val, 1);
        check("B_stall_flowid", b_cmd_id, 3);
        check("B_stall_rt_set", b_rt_set, 1);
        held = int'(b_cmd_id);
        rdb_t.delete(); rdb_id.delete();
        n0 = cmdb_t.size();
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check($sformatf("B_stall_val_%0d", i), b_cmd_val, 1);
            check($sformatf("B_stall_id_%0d", i), b_cmd_id, held);
        end
        check("B_stall_no_visits", rdb_id.size(), 0);
        b_cmd_rdy = 1'b1;
        tick(1);
        check("B_stall_single_cmd", cmdb_t.size(), n0 + 1);

        // Delete flow 2 while its rx response is outstanding
        b_hold2 = 1'b1;
        open_b(2);
        check("B_cnt_open2", b_cnt, 3);
        k = 0;
        while (!(b_resp_rdy && b_req_id == 3'd2) && k < 100) begin tick(1); k++; end
        check("B_resp2_reached", longint'(b_resp_rdy && b_req_id == 3'd2), 1);
        tick(120);
        del_b(2);
        b_hold2 = 1'b0;
        check("B_resp2_consumed", b_resp_rdy, 1);
        check("B_cnt_del2", b_cnt, 2);
        rdb_t.delete(); rdb_id.delete();
        cmdb_t.delete(); cmdb_id.delete();
        tick(300);
        cnt2 = 0;
        foreach (rdb_id[i]) if (rdb_id[i] == 2) cnt2++;
        foreach (cmdb_id[i]) if (cmdb_id[i] == 2) cnt2++;
        check("B_flow2_gone", cnt2, 0);
        check("B_others_visited", longint'(rdb_id.size() > 0), 1);

        // Same-cycle open and close of flow 1: open wins
        del_b(1);
        check("B_cnt_del1", b_cnt, 1);
        b_new_val = 1; b_new_id = 3'd1; b_new_ack = 0;
        b_del_val = 1; b_del_id = 3'd1;
        tick(1);
        b_new_val = 0; b_del_val = 0;
        check("B_cnt_new_wins", b_cnt, 2);
        rdb_t.delete(); rdb_id.delete();
        tick(40);
        cnt1 = 0;
        foreach (rdb_id[i]) if (rdb_id[i] == 1) cnt1++;
        check("B_flow1_visited", longint'(cnt1 > 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rt_timeout_scan_eng.md
Name: rt_timeout_scan_eng

Overview:
Parametrised retransmit-timeout engine for the TCP slow path. It round-robins over active flows and reads each flow's current our-ack number from rx state. It compares that number with a per-flow timer record and raises retransmit-pending in the TX scheduler only on expiry. It adds what the previous generation lacked: configurable flow count and widths, flow teardown, exponential backoff, wrap-safe deadline compare, and scheduler commands only on expiry.

Parameters:
NUM_FLOWS, 8, flows tracked; any value >= 2, not necessarily a power of two
FLOWID_W, $clog2(NUM_FLOWS), flow id width
ACK_NUM_W, 32, ack number width
TIMESTAMP_W, 32, free-running timestamp width
RT_TIMEOUT_CYCLES, 1000, base timeout in cycles; must be < 2^(TIMESTAMP_W-1) >> MAX_BACKOFF
MAX_BACKOFF, 4, saturating backoff exponent

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
new_flow_val  in  1  flow open, single-cycle strobe, always accepted
new_flow_flowid  in  FLOWID_W  flow opened
new_flow_our_ack_num  in  ACK_NUM_W  initial ack number
del_flow_val  in  1  flow close, single-cycle strobe, always accepted
del_flow_flowid  in  FLOWID_W  flow closed
rd_req_val  out  1  rx-state read request valid
rd_req_flowid  out  FLOWID_W  flow to read
rd_req_rdy  in  1  rx-state read request ready
rd_resp_val  in  1  rx-state response valid
rd_resp_our_ack_num  in  ACK_NUM_W  flow's current our-ack number
rd_resp_rdy  out  1  response ready
sched_cmd_val  out  1  scheduler command valid
sched_cmd_flowid  out  FLOWID_W  flow to mark
sched_cmd_rt_set  out  1  1 = SET rt_pend (NOP for ack/data pend implied)
sched_cmd_rdy  in  1  scheduler ready
active_cnt  out  FLOWID_W+1  number of active flows

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset: all outputs 0; active vector cleared; index, timestamp (now) and active_cnt = 0; FSM in SCAN.
- now increments every cycle and wraps modulo 2^TIMESTAMP_W.
- Timer record per flow, in 1R1W sync RAM with 1-cycle read latency: {deadline, last_ack, backoff[$clog2(MAX_BACKOFF+1)]}.
- Expired test: deadline - now, computed mod 2^TIMESTAMP_W, is zero or has MSB set. Must stay correct across now wrap.
- new_flow:
  - Sets the active bit.
  - Writes {now+RT_TIMEOUT_CYCLES, new_flow_our_ack_num, 0} that cycle.
  - Has priority on the RAM write port and the RAM read port.
  - Engine RAM accesses stall while new_flow_val = 1.
- del_flow clears the active bit.
- new and del for the same flow in the same cycle: new wins.
- active_cnt updates the cycle after a strobe. Re-opening an active flow or deleting an inactive one leaves the count unchanged.
- FSM:
  - SCAN: if active[idx], go to REQ; else idx++ (wrap NUM_FLOWS-1 -> 0). One index per cycle.
  - REQ: rd_req_val = 1, rd_req_flowid = idx; on rdy go to RESP.
  - RESP: rd_resp_rdy = 1; on val, latch ack and go to RD_TMR.
  - RD_TMR: issue RAM read when no new_flow_val; go to CALC.
  - CALC:
    - ack != last_ack: record becomes {now+RT, ack, 0}; no cmd.
    - ack == last_ack and expired: record becomes {now + (RT << min(backoff+1, MAX_BACKOFF)), ack, sat(backoff+1)}; cmd pending.
    - Otherwise: record unchanged, no cmd.
    - Go to CMD if cmd pending, else WR.
  - CMD: sched_cmd_val = 1, flowid = idx, rt_set = 1. Data held stable until rdy; then go to WR.
  - WR: write the record when no new_flow_val; idx++; go to SCAN.
- Abort: new_flow or del_flow targeting idx while the FSM is in REQ..WR aborts the visit.
  - In REQ/RESP, the pending handshake still completes.
  - A command already asserted in CMD holds until accepted.
  - Abort discards only the timer write.
  - Otherwise no cmd and no write; idx++; go to SCAN.
- Reset mid-operation returns to the reset state immediately; outstanding responses are not consumed.

Test Plan:
- Open flow 3 with ack 100 at now=10, hold rx ack at 100, RT=1000, sched_cmd_rdy=1 -> first sched cmd (flowid 3, rt_set 1) when now >= 1010. Next cmd ~2000 cycles later, then 4000; spacing saturates at 16000 (MAX_BACKOFF=4).
- Same flow, rx ack moves to 200 before expiry -> no cmd; deadline resets to now+1000; backoff 0.
- NUM_FLOWS=5, flows 0, 2, 4 active -> reads visit 0, 2, 4, 0 in order; index wraps from 4 to 0; idle slots cost one cycle each.
- Start timestamp at 2^32-100 with RT=1000 -> expiry at the wrapped value 900 is detected; no early or missed expiry.
- sched_cmd_rdy held 0 for 50 cycles during CMD -> val and flowid stable; no second cmd; other flows not visited until accept.
- del_flow 2 while in RESP for flow 2 -> response consumed; no cmd; no RAM write; active_cnt drops by 1; flow 2 never revisited. Same-cycle new and del of flow 1 -> flow 1 active.
